// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button conditioning, mode FSM and tenth-second timebase.
// Raw buttons pass through a 2-FF synchronizer and a debounce counter; a
// debounced rising edge becomes a one-cycle command. The FSM consumes the
// highest-priority armed command and drives tick/clear/display_en for the
// downstream BCD digit chain.
// The outputs carry no handshake: tick and clear are one-cycle strobes that
// the digit chain must act on in the cycle they are high. display_en is a level.
module stopwatch_ctrl #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned TICK_DIV   = 5000000,
    parameter int unsigned CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ButtonIniciar,
    input  logic       ButtonReset,
    input  logic       ButtonContar,
    input  logic       ButtonPausar,
    input  logic       ButtonParar,
    output logic       tick,
    output logic       clear,
    output logic       display_en,
    output logic [2:0] state
);

    // Button lane order: 0 arm, 1 reset, 2 count, 3 pause, 4 stop.
    localparam int unsigned NB = 5;
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        CLEARED = 3'b001,
        RUNNING = 3'b010,
        PAUSED  = 3'b011,
        STOPPED = 3'b100
    } state_e;

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_RESET,
        CMD_STOP,
        CMD_PAUSE,
        CMD_COUNT
    } cmd_e;

    logic [NB-1:0]    raw_w;
    logic [NB-1:0]    sync1_q, sync2_q;
    logic [NB-1:0]    lvl_q, lvl_d;
    logic [CNT_W-1:0] deb_cnt_q [NB];
    logic [CNT_W-1:0] deb_cnt_d [NB];
    // Only the four command buttons need edge detection; the arm switch is a level.
    logic [3:0]       lvl_prev_q;
    logic [3:0]       cmd_q;
    logic             arm_w;
    cmd_e             cmd_sel;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] presc_q, presc_d;
    logic             tick_q, tick_d;
    logic             clear_q, clear_d;

    assign raw_w = {ButtonParar, ButtonPausar, ButtonContar, ButtonReset, ButtonIniciar};
    assign arm_w = lvl_q[0];

    // Debounce: count cycles while the synchronized value disagrees with the
    // debounced level; any agreement restarts the count, so bounces never flip it.
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < NB; i++) begin
            deb_cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (deb_cnt_q[i] == DEB_LAST) begin
                    lvl_d[i] = sync2_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Input pipeline: synchronizers, debounce counters, levels and command pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            cmd_q      <= '0;
            for (int i = 0; i < NB; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= raw_w;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q[4:1];
            cmd_q      <= lvl_q[4:1] & ~lvl_prev_q;
            for (int i = 0; i < NB; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

    // Pick one command per cycle (reset > stop > pause > count); unarmed
    // commands are dropped outright rather than held for later.
    always_comb begin
        cmd_sel = CMD_NONE;
        if (arm_w) begin
            if (cmd_q[0])      cmd_sel = CMD_RESET;
            else if (cmd_q[3]) cmd_sel = CMD_STOP;
            else if (cmd_q[2]) cmd_sel = CMD_PAUSE;
            else if (cmd_q[1]) cmd_sel = CMD_COUNT;
        end
    end

    // Next-state logic for the mode FSM and the clear strobe.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        case (cmd_sel)
            CMD_RESET: begin
                state_d = CLEARED;
                clear_d = 1'b1;
            end
            CMD_STOP: begin
                if (state_q == RUNNING || state_q == PAUSED) state_d = STOPPED;
            end
            CMD_PAUSE: begin
                if (state_q == RUNNING) state_d = PAUSED;
            end
            CMD_COUNT: begin
                if (state_q == CLEARED || state_q == PAUSED || state_q == STOPPED) state_d = RUNNING;
            end
            default: ;
        endcase
    end

    // Prescaler: runs in RUNNING and PAUSED (lap keeps time), holds otherwise.
    // A reset command zeroes it and suppresses the tick so clear and tick never overlap.
    always_comb begin
        presc_d = presc_q;
        tick_d  = 1'b0;
        if (cmd_sel == CMD_RESET) begin
            presc_d = '0;
        end else if (state_q == RUNNING || state_q == PAUSED) begin
            if (presc_q == TICK_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + CNT_W'(1);
            end
        end
    end

    // State, prescaler and output strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
        end
    end

    assign tick       = tick_q;
    assign clear      = clear_q;
    assign display_en = (state_q == CLEARED) || (state_q == RUNNING);
    assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DEB_CYCLES=4, TICK_DIV=10.
// Stimulus registers each button press with the cycle its command must land;
// a cycle-level reference model turns those into expected output events
// (tick, clear, state/display change) in exp_q; a monitor pops and compares
// every event the DUT shows.
module tb_stopwatch_ctrl;

  localparam int DEB  = 4;
  localparam int TDIV = 10;
  localparam int EW   = 38;  // {cyc[31:0], tick, clear, display_en, state[2:0]}

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_PAU  = 3'd3;
  localparam logic [2:0] S_STP  = 3'd4;

  // Command mask bits.
  localparam logic [3:0] M_RESET = 4'b0001;
  localparam logic [3:0] M_COUNT = 4'b0010;
  localparam logic [3:0] M_PAUSE = 4'b0100;
  localparam logic [3:0] M_STOP  = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic b_ini = 1'b0, b_rst = 1'b0, b_cnt = 1'b0, b_pau = 1'b0, b_stp = 1'b0;
  logic tick, clear, display_en;
  logic [2:0] state;

  stopwatch_ctrl #(
    .DEB_CYCLES(DEB),
    .TICK_DIV(TDIV),
    .CNT_W(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ButtonIniciar(b_ini),
    .ButtonReset(b_rst),
    .ButtonContar(b_cnt),
    .ButtonPausar(b_pau),
    .ButtonParar(b_stp),
    .tick(tick),
    .clear(clear),
    .display_en(display_en),
    .state(state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  // Model state
  logic [2:0] m_state = S_IDLE;
  logic [2:0] m_nxt;
  logic       m_arm = 1'b0;
  logic       m_t, m_c;
  logic [3:0] m_cmds;
  int         m_act = 0;     // cycles spent counting (RUNNING/PAUSED) since last clear
  logic       pend_valid = 1'b0;
  int         pend_cyc = 0;
  logic [3:0] pend_mask = 4'b0;

  function automatic logic exp_disp(input logic [2:0] s);
    return (s == S_CLR) || (s == S_RUN);
  endfunction

  // ---------------- reference model ----------------
  // Time advances only while counting; a tick falls on every TDIV-th counting cycle.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      if (m_state != S_IDLE) exp_q.push_back({32'(cyc), 1'b0, 1'b0, 1'b0, S_IDLE});
      m_state = S_IDLE;
      m_act = 0;
      pend_valid = 1'b0;
    end else begin
      m_cmds = 4'b0;
      if (pend_valid && pend_cyc == cyc) begin
        pend_valid = 1'b0;
        if (m_arm) m_cmds = pend_mask;
      end
      m_nxt = m_state;
      m_t = 1'b0;
      m_c = 1'b0;
      if (m_cmds[0]) begin
        m_c = 1'b1;
        m_nxt = S_CLR;
        m_act = 0;
      end else begin
        if (m_state == S_RUN || m_state == S_PAU) begin
          m_act = m_act + 1;
          m_t = (m_act % TDIV) == 0;
        end
        if (m_cmds[3]) begin
          if (m_state == S_RUN || m_state == S_PAU) m_nxt = S_STP;
        end else if (m_cmds[2]) begin
          if (m_state == S_RUN) m_nxt = S_PAU;
        end else if (m_cmds[1]) begin
          if (m_state == S_CLR || m_state == S_PAU || m_state == S_STP) m_nxt = S_RUN;
        end
      end
      if (m_t || m_c || m_nxt != m_state)
        exp_q.push_back({32'(cyc), m_t, m_c, exp_disp(m_nxt), m_nxt});
      m_state = m_nxt;
    end
  end

  // ---------------- monitor ----------------
  logic [2:0]    prev_state = 3'd0;
  logic          prev_disp = 1'b0;
  logic [EW-1:0] mon_act, mon_exp;

  always @(negedge clk) begin
    if (tick || clear || state != prev_state || display_en != prev_disp) begin
      mon_act = {32'(cyc), tick, clear, display_en, state};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event: got cyc=%0d tick=%b clear=%b disp=%b state=%0d, required no event",
                 cyc, tick, clear, display_en, state);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          fails++;
          $display("FAIL event: got cyc=%0d tick=%b clear=%b disp=%b state=%0d, required cyc=%0d tick=%b clear=%b disp=%b state=%0d",
                   cyc, tick, clear, display_en, state,
                   mon_exp[37:6], mon_exp[5], mon_exp[4], mon_exp[3], mon_exp[2:0]);
        end
      end
    end
    prev_state = state;
    prev_disp = display_en;
  end

  // ---------------- driver tasks ----------------
  task automatic check_val(input string name, input logic [2:0] got, input logic [2:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Press the buttons in mask together, hold, release, then idle.
  task automatic press(input logic [3:0] mask, input int hold, input int gap);
    step();
    b_rst = mask[0];
    b_cnt = mask[1];
    b_pau = mask[2];
    b_stp = mask[3];
    pend_mask = mask;
    pend_cyc = cyc + DEB + 4;
    pend_valid = 1'b1;
    repeat (hold) step();
    b_rst = 1'b0;
    b_cnt = 1'b0;
    b_pau = 1'b0;
    b_stp = 1'b0;
    repeat (gap) step();
  endtask

  task automatic rand_press(input logic [3:0] mask);
    press(mask, DEB + 3 + $urandom_range(0, 4), DEB + 4 + $urandom_range(0, 25));
  endtask

  // Reset line chatter shorter than the debounce window: must produce nothing.
  task automatic bounce();
    step(); b_rst = 1'b1;
    step(); b_rst = 1'b0;
    step(); b_rst = 1'b1;
    step(); b_rst = 1'b0;
    repeat (DEB + 6) step();
  endtask

  task automatic set_arm(input logic v);
    step();
    b_ini = v;
    repeat (DEB + 8) step();
    m_arm = v;
  endtask

  task automatic do_rst();
    @(negedge clk);
    #1 rst = 1'b1;
    m_arm = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_state", state, S_IDLE);
    check_val("rst_tick", {2'b0, tick}, 3'd0);
    check_val("rst_clear", {2'b0, clear}, 3'd0);
    check_val("rst_disp", {2'b0, display_en}, 3'd0);
    #1 rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  int r;
  logic [3:0] msk;

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check_val("reset_state", state, S_IDLE);
    check_val("reset_tick", {2'b0, tick}, 3'd0);
    check_val("reset_clear", {2'b0, clear}, 3'd0);
    check_val("reset_disp", {2'b0, display_en}, 3'd0);
    #1 rst = 1'b0;

    // Idle, unarmed: nothing may happen.
    repeat (50) step();
    check_val("idle_state", state, S_IDLE);

    // Arm, clear, run for a while.
    set_arm(1'b1);
    press(M_RESET, 10, DEB + 6);
    check_val("after_reset_state", state, S_CLR);
    press(M_COUNT, DEB + 3, 100);
    bounce();
    check_val("after_bounce_state", state, S_RUN);

    // Lap, stop, resume from the held prescaler phase.
    press(M_PAUSE, DEB + 3, 13);
    press(M_STOP, DEB + 3, 20);
    press(M_COUNT, DEB + 3, 25);

    // Simultaneous stop and reset: reset wins.
    press(M_STOP | M_RESET, DEB + 3, 15);
    check_val("prio_state", state, S_CLR);

    // Disarmed: count ignored.
    set_arm(1'b0);
    press(M_COUNT, DEB + 3, 20);
    check_val("disarmed_state", state, S_CLR);
    set_arm(1'b1);

    // Randomized sequence.
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_rst();
        set_arm(1'b1);
      end else if (r == 1) begin
        set_arm(~m_arm);
      end else if (r == 2) begin
        bounce();
      end else if (r <= 5) begin
        msk = 4'($urandom_range(1, 15));
        rand_press(msk);
      end else if (r == 6) begin
        rand_press(M_RESET);
      end else begin
        msk = 4'b0010 << $urandom_range(0, 2);
        rand_press(msk);
      end
    end

    repeat (40) step();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL pending_events: got %0d outstanding expected events, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
